// File: rtl/spi_host_quad_pkg.sv
// Shared types and constants for the quad-lane SPI host.
package spi_host_quad_pkg;

  localparam int SPI_LANES = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    WAIT,
    HOLD,
    GAP
  } spi_host_state_t;

endpackage

// File: rtl/spi_host_quad_if.sv
// Word-level handshake between host logic (master) and the SPI controller (slave).
interface spi_host_quad_if #(
  parameter int N_BITS = 8
);

  logic [N_BITS-1:0] tx_data;
  logic              tx_last;
  logic              tx_valid;
  logic              tx_ready;
  logic [N_BITS-1:0] rx_data;
  logic              rx_valid;

  modport master (
    output tx_data, tx_last, tx_valid,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_last, tx_valid,
    output tx_ready, rx_data, rx_valid
  );

endinterface

// File: rtl/spi_host_quad_sck_div.sv
// SCK half-period timer: phase_end pulses on the last clk cycle of each CLK_DIV-long phase.
module spi_sck_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic phase_end
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign phase_end = run && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || !run || phase_end) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_host_quad.sv
// Quad-lane SPI mode-0 host: shifts words out MS-nibble first while sampling read nibbles.
module spi_host_quad
  import spi_host_quad_pkg::*;
#(
  parameter int N_BITS  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 sck,
  output logic                 cs_n,
  output logic [SPI_LANES-1:0] sdo,
  input  logic [SPI_LANES-1:0] sdi,
  spi_host_quad_if.slave       bus
);

  localparam int NIB   = N_BITS / SPI_LANES;
  localparam int NIB_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(NIB - 1);

  spi_host_state_t      state_q, state_d;
  logic                 sck_q, sck_d;
  logic                 cs_n_q, cs_n_d;
  logic [SPI_LANES-1:0] sdo_q, sdo_d;
  logic [N_BITS-1:0]    tx_shift_q, tx_shift_d;
  logic [N_BITS-1:0]    rx_shift_q, rx_shift_d;
  logic [N_BITS-1:0]    rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [NIB_W-1:0]     nib_q, nib_d;
  logic                 last_q, last_d;
  logic [N_BITS-1:0]    rx_word;
  logic                 ready;
  logic                 phase_end;
  logic                 run;
  logic                 clr;

  assign run = (state_q == LOW) || (state_q == HIGH) || (state_q == HOLD) || (state_q == GAP);
  assign clr = (state_d != state_q);

  spi_sck_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .clr       (clr),
    .phase_end (phase_end)
  );

  always_comb begin
    state_d    = state_q;
    sck_d      = sck_q;
    cs_n_d     = cs_n_q;
    sdo_d      = sdo_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    nib_d      = nib_q;
    last_d     = last_q;
    ready      = 1'b0;
    rx_word    = N_BITS'({rx_shift_q, sdi});

    case (state_q)
      IDLE: ready = 1'b1;
      LOW: begin
        if (phase_end) begin
          sck_d   = 1'b1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (phase_end) begin
          sck_d      = 1'b0;
          rx_shift_d = rx_word;
          if (nib_q != NIB_LAST) begin
            nib_d      = nib_q + 1'b1;
            sdo_d      = tx_shift_q[N_BITS-1 -: SPI_LANES];
            tx_shift_d = tx_shift_q << SPI_LANES;
            state_d    = LOW;
          end else begin
            nib_d      = '0;
            rx_data_d  = rx_word;
            rx_valid_d = 1'b1;
            if (last_q) begin
              state_d = HOLD;
            end else begin
              ready   = 1'b1;
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: ready = 1'b1;
      HOLD: begin
        if (phase_end) begin
          cs_n_d  = 1'b1;
          sdo_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (phase_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Every accepting state (IDLE, WAIT, word-end HIGH) loads the same way, overriding the case above.
    if (ready && bus.tx_valid) begin
      state_d    = LOW;
      cs_n_d     = 1'b0;
      sck_d      = 1'b0;
      sdo_d      = bus.tx_data[N_BITS-1 -: SPI_LANES];
      tx_shift_d = bus.tx_data << SPI_LANES;
      last_d     = bus.tx_last;
      nib_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sck_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      sdo_q      <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      nib_q      <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sck_q      <= sck_d;
      cs_n_q     <= cs_n_d;
      sdo_q      <= sdo_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      nib_q      <= nib_d;
      last_q     <= last_d;
    end
  end

  assign sck          = sck_q;
  assign cs_n         = cs_n_q;
  assign sdo          = sdo_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.tx_ready = rst_n & ready;

endmodule

// File: tb/tb_spi_host_quad.sv
// Bench for spi_host_quad: 8-bit/div-2 and 16-bit/div-3 instances with behavioural quad targets.
module tb_spi_host_quad;

  typedef struct {
    logic [15:0] data;
    logic        last;
    int          delay;
  } word_t;

  logic       clk;
  logic       rst_n;
  logic       sck1, cs_n1, sck2, cs_n2;
  logic [3:0] sdo1, sdi1, sdo2, sdi2;

  spi_host_quad_if #(.N_BITS(8))  bus1 ();
  spi_host_quad_if #(.N_BITS(16)) bus2 ();

  spi_host_quad #(.N_BITS(8), .CLK_DIV(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .sck(sck1), .cs_n(cs_n1), .sdo(sdo1), .sdi(sdi1), .bus(bus1)
  );

  spi_host_quad #(.N_BITS(16), .CLK_DIV(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .sck(sck2), .cs_n(cs_n2), .sdo(sdo2), .sdi(sdi2), .bus(bus2)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  resp1[$];
  logic [15:0] resp2[$];
  logic [7:0]  exp1[$];
  logic [15:0] exp2[$];

  word_t       pend[$];
  int          acc_cyc[$];
  int          rx_cyc[$];
  logic [3:0]  nib_obs[$];
  logic [15:0] rx_obs[$];
  int rises, cs_low, cs_falls, sck_hi, sdo_bad, min_hi, max_hi, min_gap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Target 1: presents the next nibble on CS fall / SCK fall, one response word per host word.
  logic [7:0] t1_word = '0;
  int         t1_k = 0;
  bit         t1_fresh = 1'b0;
  logic       t1_cs_prev, t1_sck_prev;
  always @(cs_n1 or sck1) begin
    if (t1_cs_prev !== 1'b0 && cs_n1 === 1'b0) begin
      if (!t1_fresh && resp1.size() > 0) t1_word = resp1.pop_front();
      t1_fresh = 1'b0;
      t1_k = 0;
    end else if (cs_n1 === 1'b0 && t1_sck_prev === 1'b1 && sck1 === 1'b0) begin
      t1_k++;
      if (t1_k == 2) begin
        t1_k = 0;
        t1_fresh = 1'b0;
        if (resp1.size() > 0) begin
          t1_word = resp1.pop_front();
          t1_fresh = 1'b1;
        end
      end
    end else if (sck1 === 1'b1 && t1_sck_prev !== 1'b1) begin
      t1_fresh = 1'b0;
    end
    sdi1 = 4'(t1_word >> (4 * (1 - t1_k)));
    t1_cs_prev = cs_n1;
    t1_sck_prev = sck1;
  end

  logic [15:0] t2_word = '0;
  int          t2_k = 0;
  bit          t2_fresh = 1'b0;
  logic        t2_cs_prev, t2_sck_prev;
  always @(cs_n2 or sck2) begin
    if (t2_cs_prev !== 1'b0 && cs_n2 === 1'b0) begin
      if (!t2_fresh && resp2.size() > 0) t2_word = resp2.pop_front();
      t2_fresh = 1'b0;
      t2_k = 0;
    end else if (cs_n2 === 1'b0 && t2_sck_prev === 1'b1 && sck2 === 1'b0) begin
      t2_k++;
      if (t2_k == 4) begin
        t2_k = 0;
        t2_fresh = 1'b0;
        if (resp2.size() > 0) begin
          t2_word = resp2.pop_front();
          t2_fresh = 1'b1;
        end
      end
    end else if (sck2 === 1'b1 && t2_sck_prev !== 1'b1) begin
      t2_fresh = 1'b0;
    end
    sdi2 = 4'(t2_word >> (4 * (3 - t2_k)));
    t2_cs_prev = cs_n2;
    t2_sck_prev = sck2;
  end

  task automatic clear_obs();
    acc_cyc.delete(); rx_cyc.delete(); nib_obs.delete(); rx_obs.delete();
    rises = 0; cs_low = 0; cs_falls = 0; sck_hi = 0; sdo_bad = 0;
    min_hi = 1000; max_hi = 0; min_gap = 1000;
  endtask

  // Drives words from pend (sel 0 -> dut1, 1 -> dut2) and records pin activity for ncyc cycles.
  task automatic watch(input int sel, input int ncyc);
    logic p_sck, p_cs, o_sck, o_cs, o_rv, o_rdy, valid, last;
    logic [3:0]  p_sdo, o_sdo;
    logic [15:0] o_rd, d;
    int  hi_run, gap_run, stall;
    bit  acc_pend, seen_low;
    p_sck = sel ? sck2 : sck1;
    p_cs  = sel ? cs_n2 : cs_n1;
    p_sdo = sel ? sdo2 : sdo1;
    hi_run = 0; gap_run = 0; stall = -1; acc_pend = 0; seen_low = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      o_sck = sel ? sck2 : sck1;
      o_cs  = sel ? cs_n2 : cs_n1;
      o_sdo = sel ? sdo2 : sdo1;
      o_rv  = sel ? bus2.rx_valid : bus1.rx_valid;
      o_rd  = sel ? bus2.rx_data : {8'h00, bus1.rx_data};
      o_rdy = sel ? bus2.tx_ready : bus1.tx_ready;
      if (!p_sck && o_sck) begin rises++; nib_obs.push_back(o_sdo); end
      if (o_sck) begin hi_run++; sck_hi++; end
      if (p_sck && !o_sck) begin
        if (hi_run < min_hi) min_hi = hi_run;
        if (hi_run > max_hi) max_hi = hi_run;
        hi_run = 0;
      end
      if (p_sck && o_sck && o_sdo !== p_sdo) sdo_bad++;
      if (!o_cs) cs_low++;
      if (p_cs && !o_cs) begin
        cs_falls++;
        if (seen_low && gap_run < min_gap) min_gap = gap_run;
        gap_run = 0;
      end
      if (o_cs) gap_run++;
      if (!o_cs) seen_low = 1;
      if (o_rv) begin rx_obs.push_back(o_rd); rx_cyc.push_back(c); end
      if (acc_pend) begin
        void'(pend.pop_front());
        acc_pend = 0;
        stall = -1;
      end
      valid = 1'b0; last = 1'b0; d = '0;
      if (pend.size() > 0) begin
        if (stall < 0) stall = pend[0].delay;
        if (stall > 0) stall--;
        else begin valid = 1'b1; d = pend[0].data; last = pend[0].last; end
      end
      if (sel) begin
        bus2.tx_valid = valid; bus2.tx_data = d; bus2.tx_last = last;
      end else begin
        bus1.tx_valid = valid; bus1.tx_data = d[7:0]; bus1.tx_last = last;
      end
      if (valid && o_rdy) begin acc_pend = 1; acc_cyc.push_back(c); end
      p_sck = o_sck; p_cs = o_cs; p_sdo = o_sdo;
    end
    bus1.tx_valid = 1'b0;
    bus2.tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus1.tx_valid = 1'b0; bus1.tx_data = '0; bus1.tx_last = 1'b0;
    bus2.tx_valid = 1'b0; bus2.tx_data = '0; bus2.tx_last = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (cs_n1 !== 1'b1) begin bad++; $display("FAIL reset_cs_n: got %b want 1", cs_n1); end
    total++; if (sck1 !== 1'b0) begin bad++; $display("FAIL reset_sck: got %b want 0", sck1); end
    total++; if (sdo1 !== 4'h0) begin bad++; $display("FAIL reset_sdo: got %h want 0", sdo1); end
    total++; if (bus1.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid: got %b want 0", bus1.rx_valid); end
    total++; if (bus1.rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %h want 00", bus1.rx_data); end
    total++; if (bus1.tx_ready !== 1'b0) begin bad++; $display("FAIL reset_tx_ready: got %b want 0", bus1.tx_ready); end
    total++; if (cs_n2 !== 1'b1) begin bad++; $display("FAIL reset_cs_n2: got %b want 1", cs_n2); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus1.tx_ready !== 1'b1) begin bad++; $display("FAIL idle_tx_ready: got %b want 1", bus1.tx_ready); end
  endtask

  task automatic test_single();
    logic [15:0] got, e;
    clear_obs();
    resp1.push_back(8'h3C); exp1.push_back(8'h3C);
    pend.push_back('{16'h00A5, 1'b1, 0});
    watch(0, 20);
    total++; if (rises != 2) begin bad++; $display("FAIL single_rises: got %0d want 2", rises); end
    total++; if (nib_obs.size() != 2 || nib_obs[0] !== 4'hA || nib_obs[1] !== 4'h5) begin
      bad++; $display("FAIL single_nibbles: got %p want A,5", nib_obs); end
    total++; if (cs_low != 10) begin bad++; $display("FAIL single_cs_low: got %0d want 10", cs_low); end
    total++; if (sdo_bad != 0) begin bad++; $display("FAIL single_sdo_stable: got %0d changes want 0", sdo_bad); end
    total++; if (rx_obs.size() != 1) begin bad++; $display("FAIL single_rx_count: got %0d want 1", rx_obs.size()); end
    total++; if (acc_cyc.size() != 1 || rx_cyc.size() != 1 || rx_cyc[0] - acc_cyc[0] != 9) begin
      bad++; $display("FAIL single_rx_latency: got %p / %p want 9 apart", acc_cyc, rx_cyc); end
    while (rx_obs.size() > 0 && exp1.size() > 0) begin
      got = rx_obs.pop_front(); e = {8'h00, exp1.pop_front()};
      total++; if (got !== e) begin bad++; $display("FAIL single_rx_data: got %h want %h", got, e); end
    end
    exp1.delete();
    total++; if (bus1.rx_data !== 8'h3C) begin bad++; $display("FAIL single_rx_hold: got %h want 3C", bus1.rx_data); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got, e;
    clear_obs();
    resp1.push_back(8'h9E); resp1.push_back(8'h61);
    exp1.push_back(8'h9E); exp1.push_back(8'h61);
    pend.push_back('{16'h0012, 1'b0, 0});
    pend.push_back('{16'h0034, 1'b1, 0});
    watch(0, 30);
    total++; if (cs_falls != 1 || cs_low != 18) begin
      bad++; $display("FAIL b2b_cs: got falls=%0d low=%0d want 1/18", cs_falls, cs_low); end
    total++; if (rises != 4) begin bad++; $display("FAIL b2b_rises: got %0d want 4", rises); end
    total++; if (acc_cyc.size() != 2 || acc_cyc[1] - acc_cyc[0] != 8) begin
      bad++; $display("FAIL b2b_word_end_accept: got %p want 8 apart", acc_cyc); end
    total++; if (nib_obs.size() != 4 || nib_obs[0] !== 4'h1 || nib_obs[1] !== 4'h2 ||
                 nib_obs[2] !== 4'h3 || nib_obs[3] !== 4'h4) begin
      bad++; $display("FAIL b2b_nibbles: got %p want 1,2,3,4", nib_obs); end
    total++; if (rx_obs.size() != 2 || rx_cyc[1] - rx_cyc[0] != 8) begin
      bad++; $display("FAIL b2b_rx_pulses: got %0d at %p want 2 pulses 8 apart", rx_obs.size(), rx_cyc); end
    while (rx_obs.size() > 0 && exp1.size() > 0) begin
      got = rx_obs.pop_front(); e = {8'h00, exp1.pop_front()};
      total++; if (got !== e) begin bad++; $display("FAIL b2b_rx_data: got %h want %h", got, e); end
    end
    exp1.delete();
  endtask

  task automatic test_stall();
    logic [15:0] got, e;
    clear_obs();
    resp1.push_back(8'h0F); resp1.push_back(8'hF0);
    exp1.push_back(8'h0F); exp1.push_back(8'hF0);
    pend.push_back('{16'h0077, 1'b0, 0});
    pend.push_back('{16'h0088, 1'b1, 20});
    watch(0, 50);
    total++; if (cs_falls != 1 || cs_low != 31) begin
      bad++; $display("FAIL stall_cs: got falls=%0d low=%0d want 1/31", cs_falls, cs_low); end
    total++; if (sck_hi != 8) begin bad++; $display("FAIL stall_sck_high: got %0d want 8", sck_hi); end
    total++; if (acc_cyc.size() != 2 || acc_cyc[1] - acc_cyc[0] != 21) begin
      bad++; $display("FAIL stall_accept: got %p want 21 apart", acc_cyc); end
    total++; if (nib_obs.size() != 4 || nib_obs[0] !== 4'h7 || nib_obs[1] !== 4'h7 ||
                 nib_obs[2] !== 4'h8 || nib_obs[3] !== 4'h8) begin
      bad++; $display("FAIL stall_nibbles: got %p want 7,7,8,8", nib_obs); end
    total++; if (rx_obs.size() != 2) begin bad++; $display("FAIL stall_rx_count: got %0d want 2", rx_obs.size()); end
    while (rx_obs.size() > 0 && exp1.size() > 0) begin
      got = rx_obs.pop_front(); e = {8'h00, exp1.pop_front()};
      total++; if (got !== e) begin bad++; $display("FAIL stall_rx_data: got %h want %h", got, e); end
    end
    exp1.delete();
  endtask

  task automatic test_hold_gap();
    logic [15:0] got, e;
    clear_obs();
    resp1.push_back(8'hA1); resp1.push_back(8'hB2);
    exp1.push_back(8'hA1); exp1.push_back(8'hB2);
    pend.push_back('{16'h005A, 1'b1, 0});
    pend.push_back('{16'h00C3, 1'b1, 0});
    watch(0, 40);
    total++; if (acc_cyc.size() != 2 || acc_cyc[1] - acc_cyc[0] != 13) begin
      bad++; $display("FAIL holdgap_accept: got %p want 13 apart", acc_cyc); end
    total++; if (cs_falls != 2 || min_gap < 2) begin
      bad++; $display("FAIL holdgap_cs_high: got falls=%0d gap=%0d want 2 falls gap>=2", cs_falls, min_gap); end
    total++; if (rx_obs.size() != 2) begin bad++; $display("FAIL holdgap_rx_count: got %0d want 2", rx_obs.size()); end
    while (rx_obs.size() > 0 && exp1.size() > 0) begin
      got = rx_obs.pop_front(); e = {8'h00, exp1.pop_front()};
      total++; if (got !== e) begin bad++; $display("FAIL holdgap_rx_data: got %h want %h", got, e); end
    end
    exp1.delete();
  endtask

  task automatic test_abort();
    clear_obs();
    resp1.push_back(8'h66);
    pend.push_back('{16'h0099, 1'b1, 0});
    watch(0, 4);
    total++; if (sck1 !== 1'b1) begin bad++; $display("FAIL abort_in_high: got sck=%b want 1", sck1); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (cs_n1 !== 1'b1 || sck1 !== 1'b0 || sdo1 !== 4'h0) begin
      bad++; $display("FAIL abort_pins: got cs_n=%b sck=%b sdo=%h want 1/0/0", cs_n1, sck1, sdo1); end
    total++; if (bus1.tx_ready !== 1'b0) begin bad++; $display("FAIL abort_tx_ready: got %b want 0", bus1.tx_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (bus1.tx_ready !== 1'b1) begin bad++; $display("FAIL abort_release_ready: got %b want 1", bus1.tx_ready); end
    clear_obs();
    watch(0, 20);
    total++; if (rx_obs.size() != 0 || cs_falls != 0) begin
      bad++; $display("FAIL abort_no_rx: got rx=%0d cs_falls=%0d want 0/0", rx_obs.size(), cs_falls); end
  endtask

  task automatic test_wide();
    logic [15:0] got, e;
    clear_obs();
    resp2.push_back(16'h1234); exp2.push_back(16'h1234);
    pend.push_back('{16'hBEEF, 1'b1, 0});
    watch(1, 40);
    total++; if (min_hi != 3 || max_hi != 3) begin
      bad++; $display("FAIL wide_half_period: got min=%0d max=%0d want 3", min_hi, max_hi); end
    total++; if (cs_low != 27) begin bad++; $display("FAIL wide_cs_low: got %0d want 27", cs_low); end
    total++; if (nib_obs.size() != 4 || nib_obs[0] !== 4'hB || nib_obs[1] !== 4'hE ||
                 nib_obs[2] !== 4'hE || nib_obs[3] !== 4'hF) begin
      bad++; $display("FAIL wide_nibbles: got %p want B,E,E,F", nib_obs); end
    total++; if (acc_cyc.size() != 1 || rx_cyc.size() != 1 || rx_cyc[0] - acc_cyc[0] != 25) begin
      bad++; $display("FAIL wide_rx_latency: got %p / %p want 25 apart", acc_cyc, rx_cyc); end
    total++; if (sdo_bad != 0) begin bad++; $display("FAIL wide_sdo_stable: got %0d changes want 0", sdo_bad); end
    total++; if (rx_obs.size() != 1) begin bad++; $display("FAIL wide_rx_count: got %0d want 1", rx_obs.size()); end
    while (rx_obs.size() > 0 && exp2.size() > 0) begin
      got = rx_obs.pop_front(); e = exp2.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL wide_rx_data: got %h want %h", got, e); end
    end
    exp2.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_hold_gap();
    test_abort();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
